// File: rtl/seq_mult_unit.sv
// rtl/seq_mult_unit.sv - multi-cycle shift-add multiplier with valid/ready handshakes (SEQ_MULT_SIGNED_EN selects signed operands)
module seq_mult_unit #(
    parameter int DATA_WIDTH_I = 32,
    parameter int DATA_WIDTH_O = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH_I-1:0] a,
    input  logic [DATA_WIDTH_I-1:0] b,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH_O-1:0] res,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int CW = $clog2(DATA_WIDTH_I);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH_I - 1);

    if (DATA_WIDTH_O != 2 * DATA_WIDTH_I) begin : g_width_chk
        $error("seq_mult_unit: DATA_WIDTH_O must equal 2*DATA_WIDTH_I");
    end
    if (DATA_WIDTH_I < 2) begin : g_min_chk
        $error("seq_mult_unit: DATA_WIDTH_I must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q,     state_d;
    logic [CW-1:0]             cnt_q,       cnt_d;
    logic [DATA_WIDTH_I-1:0]   mcand_q,     mcand_d;
    logic [DATA_WIDTH_I-1:0]   mplier_q,    mplier_d;
    logic [DATA_WIDTH_O-1:0]   acc_q,       acc_d;
    logic [DATA_WIDTH_O-1:0]   res_q,       res_d;
    logic                      out_valid_q, out_valid_d;
    logic                      in_ready_q,  in_ready_d;

    logic [DATA_WIDTH_I-1:0]   op_a;
    logic [DATA_WIDTH_I-1:0]   op_b;
    logic [DATA_WIDTH_O-1:0]   addend;
    logic [DATA_WIDTH_O-1:0]   acc_sum;
    logic [DATA_WIDTH_O-1:0]   final_res;

`ifdef SEQ_MULT_SIGNED_EN
    logic sign_q, sign_d;

    // Magnitudes of the operands; the most-negative value maps to 2^(W-1) as unsigned
    always_comb begin
        op_a = a[DATA_WIDTH_I-1] ? (-a) : a;
        op_b = b[DATA_WIDTH_I-1] ? (-b) : b;
    end
`else
    // Unsigned build: operands pass straight through
    always_comb begin
        op_a = a;
        op_b = b;
    end
`endif

    // Partial product for the current multiplier bit and the running sum
    always_comb begin
        addend  = mplier_q[0] ? ({{DATA_WIDTH_I{1'b0}}, mcand_q} << cnt_q) : '0;
        acc_sum = acc_q + addend;
`ifdef SEQ_MULT_SIGNED_EN
        final_res = sign_q ? (-acc_sum) : acc_sum;
`else
        final_res = acc_sum;
`endif
    end

    // Next-state and datapath updates for the IDLE/BUSY/DONE sequence
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
`ifdef SEQ_MULT_SIGNED_EN
        sign_d      = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d  = BUSY;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef SEQ_MULT_SIGNED_EN
                    sign_d   = a[DATA_WIDTH_I-1] ^ b[DATA_WIDTH_I-1];
`endif
                end
            end
            BUSY: begin
                acc_d    = acc_sum;
                mplier_d = mplier_q >> 1;
                if (cnt_q == LAST_BIT) begin
                    state_d     = DONE;
                    res_d       = final_res;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        // in_ready is registered from the next state so it never sees in_valid
        in_ready_d = (state_d == IDLE);
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q      <= sign_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// tb/tb_seq_mult_unit.sv - directed self-checking bench for seq_mult_unit
module tb_seq_mult_unit;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] res;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    seq_mult_unit #(.DATA_WIDTH_I(32), .DATA_WIDTH_O(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res       (res),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
`ifdef SEQ_MULT_SIGNED_EN
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        return 64'(sx * sy);
`else
        return {32'd0, x} * {32'd0, y};
`endif
    endfunction

    task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("accept_ready", {63'd0, in_ready}, 64'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [63:0] exp);
        int lat        = 0;
        bit ready_busy = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_busy = 1;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd32);
        check({tag, "_res"}, res, exp);
        check({tag, "_ready_busy"}, {63'd0, ready_busy | in_ready}, 64'd0);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_ready_back"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [63:0] held;
        bit          flag_a;
        bit          flag_b;
        bit          flag_c;
        logic [63:0] exp_q[$];
        logic [31:0] av;
        logic [31:0] bv;
        int          cyc;
        int          last_acc;
        int          n_acc;
        int          n_res;

        rst       = 1'b0;
        a         = '0;
        b         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // 1. reset state, release, 3*5
        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_res", res, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_in_ready", {63'd0, in_ready}, 64'd1);
        start_op(32'd3, 32'd5);
        wait_result("t1", 64'd15);
        release_result("t1");

`ifndef SEQ_MULT_SIGNED_EN
        // 2. maximum unsigned operands
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("t2", 64'hFFFF_FFFE_0000_0001);
        release_result("t2");
`endif

        // 3. back-pressure: result held, new operands ignored
        start_op(32'd1234, 32'd5678);
        wait_result("t3", ref_mul(32'd1234, 32'd5678));
        held   = res;
        flag_a = 0;
        flag_b = 0;
        flag_c = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin a = 32'd9; b = 32'd9; in_valid = 1'b1; end
            if (i == 4) in_valid = 1'b0;
            @(negedge clk);
            if (!out_valid) flag_a = 1;
            if (res !== held) flag_b = 1;
            if (in_ready) flag_c = 1;
        end
        check("t3_valid_held", {63'd0, flag_a}, 64'd0);
        check("t3_res_stable", {63'd0, flag_b}, 64'd0);
        check("t3_ready_low", {63'd0, flag_c}, 64'd0);
        release_result("t3");
        flag_a = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) flag_a = 1;
        end
        check("t3_no_accept", {63'd0, flag_a}, 64'd0);
        check("t3_res_kept", res, held);

        // 4. reset in the middle of BUSY
        start_op(32'd100, 32'd200);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t4_valid", {63'd0, out_valid}, 64'd0);
        check("t4_res", res, 64'd0);
        check("t4_ready", {63'd0, in_ready}, 64'd0);
        rst    = 1'b1;
        flag_a = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) flag_a = 1;
        end
        check("t4_no_partial", {63'd0, flag_a}, 64'd0);
        start_op(32'd7, 32'd6);
        wait_result("t4", 64'd42);
        release_result("t4");

`ifdef SEQ_MULT_SIGNED_EN
        // 5. signed operands
        start_op(32'hFFFF_FFFD, 32'd5);
        wait_result("t5a", 64'hFFFF_FFFF_FFFF_FFF1);
        release_result("t5a");
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("t5b", 64'd1);
        release_result("t5b");
        start_op(32'h8000_0000, 32'h8000_0000);
        wait_result("t5c", 64'h4000_0000_0000_0000);
        release_result("t5c");
`endif

        // 6. streaming at full rate with random operands
        out_ready = 1'b1;
        in_valid  = 1'b1;
        cyc       = 0;
        last_acc  = -1;
        n_acc     = 0;
        n_res     = 0;
        flag_a    = 0;
        while (n_res < 4 && cyc < 400) begin
            if (n_acc >= 4) in_valid = 1'b0;
            if (out_valid) begin
                if (in_ready) flag_a = 1;
                if (exp_q.size() > 0) check("t6_res", res, exp_q.pop_front());
                n_res++;
            end
            if (in_ready && n_acc < 4) begin
                if (last_acc >= 0) check("t6_period", 64'(cyc - last_acc), 64'd34);
                last_acc = cyc;
                av = $urandom;
                bv = $urandom;
                a  = av;
                b  = bv;
                exp_q.push_back(ref_mul(av, bv));
                n_acc++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("t6_results", 64'(n_res), 64'd4);
        check("t6_overlap", {63'd0, flag_a}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
